init_pop: RTL and testbench

// - Builds the initial genetic-algorithm population: NPATH paths of PATH_W bits, filled with

---
 rtl/init_pop.sv | 99 +++++++++
 tb/tb_init_pop.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/init_pop.sv
`default_nettype none
// ============================================================================
// init_pop : fills an NPATH x PATH_W population, CHUNK_W bits per cycle,
//            from an xorshift32 stream seeded at start.
// Option   : define INIT_POP_START_PULSE_EN for rising-edge start acceptance.
// Revision : 1.0
// ============================================================================
module init_pop #(
  parameter int NPATH   = 50,
  parameter int PATH_W  = 150,
  parameter int CHUNK_W = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [31:0]             i_prg_seed,
  output logic [NPATH*PATH_W-1:0] o_population,
  output logic                    o_done
);

  localparam int c_NCHUNK = (NPATH * PATH_W) / CHUNK_W;
  localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NCHUNK - 1);
  // xorshift32 has an all-zero fixed point, so a zero seed is replaced
  localparam logic [31:0] c_ZERO_SEED_SUB = 32'h2545F491;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [31:0]               r_rng;
  logic [c_IDX_W-1:0]        r_idx;
  logic [NPATH*PATH_W-1:0]   r_pop;
  logic                      r_done;
  logic                      w_start_ok;
  logic [31:0]               w_next;

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  assign w_next = xs32(r_rng);

`ifdef INIT_POP_START_PULSE_EN
  logic r_start_q;

  always_ff @(posedge clk) begin
    if (rst) r_start_q <= 1'b0;
    else     r_start_q <= i_start;
  end

  assign w_start_ok = i_start & ~r_start_q;
`else
  assign w_start_ok = i_start;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rng   <= 32'h0;
      r_idx   <= '0;
      r_pop   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_rng   <= (i_prg_seed == 32'h0) ? c_ZERO_SEED_SUB : i_prg_seed;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_rng <= w_next;
          r_pop[r_idx*CHUNK_W +: CHUNK_W] <= w_next[CHUNK_W-1:0];
          r_idx <= r_idx + 1'b1;
          if (r_idx == c_LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_population = r_pop;
  assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_init_pop.sv
`default_nettype none
// ============================================================================
// tb_init_pop : scoreboard bench for init_pop against an xorshift32 model.
// Revision    : 1.0
// ============================================================================
module tb_init_pop;

  localparam int NPATH   = 50;
  localparam int PATH_W  = 150;
  localparam int CHUNK_W = 30;
  localparam int P       = NPATH * PATH_W;
  localparam int NCHUNK  = P / CHUNK_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [31:0]  i_prg_seed;
  logic [P-1:0] w_pop;
  logic         w_done;

  int n_chk  = 0;
  int n_fail = 0;
  logic [P-1:0] exp_q[$];

  init_pop #(
    .NPATH  (NPATH),
    .PATH_W (PATH_W),
    .CHUNK_W(CHUNK_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_prg_seed  (i_prg_seed),
    .o_population(w_pop),
    .o_done      (w_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs_model(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [P-1:0] model_pop(input logic [31:0] seed);
    logic [P-1:0] p;
    logic [31:0]  x;
    p = '0;
    x = (seed == 32'h0) ? 32'h2545F491 : seed;
    for (int k = 0; k < NCHUNK; k++) begin
      x = xs_model(x);
      p[k*CHUNK_W +: CHUNK_W] = x[CHUNK_W-1:0];
    end
    return p;
  endfunction

  function automatic int chunk_diff(input logic [P-1:0] a, input logic [P-1:0] b);
    int cnt;
    cnt = 0;
    for (int k = 0; k < NCHUNK; k++)
      if (a[k*CHUNK_W +: CHUNK_W] !== b[k*CHUNK_W +: CHUNK_W]) cnt++;
    return cnt;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // glitch_at < 0 disables the mid-run start pulse
  task automatic run_seed(input logic [31:0] seed, input int glitch_at,
                          input logic [31:0] glitch_seed, input string tag);
    int n;
    logic [P-1:0] e;
    i_prg_seed = seed;
    i_start    = 1'b1;
    exp_q.push_back(model_pop(seed));
    tick();
    i_start = 1'b0;
    n = 0;
    while (!w_done && n < 400) begin
      if (n == glitch_at) begin
        i_start    = 1'b1;
        i_prg_seed = glitch_seed;
      end else begin
        i_start = 1'b0;
      end
      tick();
      n++;
    end
    i_start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(NCHUNK));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pop_bad_chunks"}, 64'(chunk_diff(w_pop, e)), 64'd0);
    end
  endtask

  initial begin
    logic [P-1:0] saved;
    int seen, rises, hi, r1, r2;
    logic prev;

    rst        = 1'b1;
    i_start    = 1'b0;
    i_prg_seed = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_pop", 64'(chunk_diff(w_pop, {P{1'b0}})), 64'd0);
    check("rst_done", 64'(w_done), 64'd0);

    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (w_done) seen++;
    end
    check("idle_done_seen", 64'(seen), 64'd0);
    check("idle_pop", 64'(chunk_diff(w_pop, {P{1'b0}})), 64'd0);

    run_seed(32'h1, -1, 32'h0, "seed1");
    check("seed1_chunk0", 64'(w_pop[29:0]), 64'h0042021);

    repeat (20) tick();
    check("done_hold", 64'(w_done), 64'd1);
    check("done_hold_pop", 64'(chunk_diff(w_pop, model_pop(32'h1))), 64'd0);

    run_seed(32'h0, -1, 32'h0, "seed0");
    saved = w_pop;
    check("seed0_nonzero", 64'(w_pop != {P{1'b0}}), 64'd1);
    run_seed(32'h2545F491, -1, 32'h0, "seed_alias");
    check("seed0_alias_match", 64'(chunk_diff(w_pop, saved)), 64'd0);

    run_seed(32'hDEADBEEF, 100, 32'h1, "run_start_ignored");

    i_prg_seed = 32'hCAFEF00D;
    i_start    = 1'b1;
    exp_q.push_back(model_pop(32'hCAFEF00D));
    tick();
    i_start = 1'b0;
    repeat (120) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_pop", 64'(chunk_diff(w_pop, {P{1'b0}})), 64'd0);
    check("midrst_done", 64'(w_done), 64'd0);
    repeat (10) tick();
    check("midrst_idle_pop", 64'(chunk_diff(w_pop, {P{1'b0}})), 64'd0);
    check("midrst_idle_done", 64'(w_done), 64'd0);

    run_seed(32'h7, -1, 32'h0, "post_rst");

    i_prg_seed = 32'h5;
    i_start    = 1'b1;
    rises = 0;
    hi    = 0;
    r1    = -1;
    r2    = -1;
    prev  = w_done;
    for (int n = 1; n <= 600; n++) begin
      tick();
      if (w_done && !prev) begin
        rises++;
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      if (w_done) hi++;
      prev = w_done;
    end
    i_start = 1'b0;
    check("held_first_done", 64'(r1), 64'(NCHUNK + 1));
    check("held_pop", 64'(chunk_diff(w_pop, model_pop(32'h5))), 64'd0);
`ifdef INIT_POP_START_PULSE_EN
    check("held_rises", 64'(rises), 64'd1);
    check("held_done_level", 64'(w_done), 64'd1);
    check("held_done_cycles", 64'(hi), 64'd350);
`else
    check("held_rises", 64'(rises), 64'd2);
    check("held_period", 64'(r2 - r1), 64'(NCHUNK + 1));
    check("held_done_cycles", 64'(hi), 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
